// File: rtl/conv_cfg_pkg.sv
// Shared layer constants, sequencer state and tap tag types
// for the convolution address sequencer.
package conv_cfg_pkg;

    localparam int K_DEF        = 5;
    localparam int IN_SIZE_DEF  = 32;
    localparam int IN_CH_DEF    = 1;
    localparam int OUT_CH_DEF   = 6;
    localparam int LANES_DEF    = 4;
    localparam int ADDR_W_DEF   = 16;
    localparam int DATA_LAT_DEF = 2;
    localparam int MAC_LAT_DEF  = 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    // Per-tap flags; the output address travels next to them in the
    // top level because its width is a module parameter.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } tag_t;

    function automatic int ceil_div(input int a, input int b);
        return (b == 0) ? 0 : (a + b - 1) / b;
    endfunction

    // Counter width that never collapses to zero bits
    function automatic int clog2w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Fixed-depth register chain used to align tap tags with the
// operand and result timing of the accumulator datapath.
module tag_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_regs
        logic [WIDTH-1:0] sr [DEPTH];

        // Shift every cycle with no enable so bubbles travel with the data
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
            end else begin
                sr[0] <= d;
                for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
            end
        end

        assign q = sr[DEPTH-1];
    end

endmodule

// File: rtl/conv_addr_sequencer.sv
// Self-sequencing loop nest (m,r,c,g,i,j) that issues IFM/weight
// addresses and pipeline-aligned accumulator and write strobes.
module conv_addr_sequencer
    import conv_cfg_pkg::*;
#(
    parameter int K        = K_DEF,
    parameter int IN_SIZE  = IN_SIZE_DEF,
    parameter int IN_CH    = IN_CH_DEF,
    parameter int OUT_CH   = OUT_CH_DEF,
    parameter int LANES    = LANES_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_LAT = DATA_LAT_DEF,
    parameter int MAC_LAT  = MAC_LAT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stall,
    output logic              busy,
    output logic              done,
    output logic              addr_valid,
    output logic [ADDR_W-1:0] ifm_addr,
    output logic [ADDR_W-1:0] weight_addr,
    output logic              acc_clear,
    output logic              acc_en,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr
);

    localparam int OUT_SIZE  = IN_SIZE - K + 1;
    localparam int NG        = ceil_div(IN_CH, LANES);
    localparam int KK        = K * K;
    localparam int TAPS      = NG * KK;
    localparam int IN_SQ     = IN_SIZE * IN_SIZE;
    localparam int OUT_SQ    = OUT_SIZE * OUT_SIZE;
    localparam int DRAIN_LEN = DATA_LAT + MAC_LAT;

    localparam int KW = clog2w(K);
    localparam int GW = clog2w(NG);
    localparam int PW = clog2w(OUT_SIZE);
    localparam int MW = clog2w(OUT_CH);
    localparam int DW = clog2w(DRAIN_LEN + 1);

    localparam logic [KW-1:0] K_MAX = KW'(K - 1);
    localparam logic [GW-1:0] G_MAX = GW'(NG - 1);
    localparam logic [PW-1:0] P_MAX = PW'(OUT_SIZE - 1);
    localparam logic [MW-1:0] M_MAX = MW'(OUT_CH - 1);
    localparam logic [DW-1:0] D_MAX = DW'(DRAIN_LEN);

    localparam longint LIMIT   = longint'(1) << ADDR_W;
    localparam longint MAX_IFM = longint'(NG) * IN_SQ - 1;
    localparam longint MAX_WGT = longint'(OUT_CH) * TAPS - 1;
    localparam longint MAX_OUT = longint'(OUT_CH) * OUT_SQ - 1;

    if (LANES == 0) begin : g_bad_lanes
        $error("conv_addr_sequencer: LANES must be nonzero");
    end
    if (K > IN_SIZE) begin : g_bad_k
        $error("conv_addr_sequencer: kernel larger than input map");
    end
    if (MAX_IFM >= LIMIT || MAX_WGT >= LIMIT || MAX_OUT >= LIMIT) begin : g_bad_w
        $error("conv_addr_sequencer: ADDR_W too narrow for layer");
    end

    typedef struct packed {
        tag_t              f;
        logic [ADDR_W-1:0] out_addr;
    } tap_tag_t;

    state_t          state;
    logic [DW-1:0]   drain_cnt;
    logic [MW-1:0]   m;
    logic [PW-1:0]   r;
    logic [PW-1:0]   c;
    logic [GW-1:0]   g;
    logic [KW-1:0]   i;
    logic [KW-1:0]   j;
    tap_tag_t        tag_q;
    tap_tag_t        acc_tag;
    logic [ADDR_W:0] wr_d;
    logic [ADDR_W:0] wr_q;

    logic start_ok, issue;
    logic j_wrap, i_wrap, g_wrap, c_wrap, r_wrap, m_wrap;
    logic tap_wrap, last_tap;

    assign start_ok = (state == IDLE) && start;
    assign issue    = (state == RUN) && !stall;

    assign j_wrap   = (j == K_MAX);
    assign i_wrap   = (i == K_MAX);
    assign g_wrap   = (g == G_MAX);
    assign c_wrap   = (c == P_MAX);
    assign r_wrap   = (r == P_MAX);
    assign m_wrap   = (m == M_MAX);
    assign tap_wrap = j_wrap && i_wrap && g_wrap;
    assign last_tap = issue && tap_wrap && c_wrap && r_wrap && m_wrap;

    // Layer FSM: accept start in IDLE, drain the tag pipeline, pulse done
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            drain_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (last_tap) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end
                end
                DRAIN: begin
                    if (done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (drain_cnt == D_MAX) begin
                        done <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Loop nest, innermost j; each wrap carries outward, frozen on stall
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {m, r, c, g, i, j} <= '0;
        end else if (start_ok) begin
            {m, r, c, g, i, j} <= '0;
        end else if (issue) begin
            j <= j_wrap ? '0 : j + 1'b1;
            if (j_wrap)
                i <= i_wrap ? '0 : i + 1'b1;
            if (j_wrap && i_wrap)
                g <= g_wrap ? '0 : g + 1'b1;
            if (tap_wrap)
                c <= c_wrap ? '0 : c + 1'b1;
            if (tap_wrap && c_wrap)
                r <= r_wrap ? '0 : r + 1'b1;
            if (tap_wrap && c_wrap && r_wrap)
                m <= m_wrap ? '0 : m + 1'b1;
        end
    end

    // Address stage: registered addresses and the tag for the issued tap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_valid  <= 1'b0;
            ifm_addr    <= '0;
            weight_addr <= '0;
            tag_q       <= '0;
        end else begin
            addr_valid    <= issue;
            tag_q.f.valid <= issue;
            tag_q.f.first <= issue && (g == '0) && (i == '0) && (j == '0);
            tag_q.f.last  <= issue && tap_wrap;
            if (issue) begin
                ifm_addr <= ADDR_W'(32'(g) * 32'(IN_SQ)
                          + (32'(r) + 32'(i)) * 32'(IN_SIZE)
                          + 32'(c) + 32'(j));
                weight_addr <= ADDR_W'(32'(m) * 32'(TAPS)
                             + 32'(g) * 32'(KK)
                             + 32'(i) * 32'(K) + 32'(j));
                tag_q.out_addr <= ADDR_W'(32'(m) * 32'(OUT_SQ)
                                + 32'(r) * 32'(OUT_SIZE) + 32'(c));
            end
        end
    end

    tag_delay_line #(
        .WIDTH ($bits(tap_tag_t)),
        .DEPTH (DATA_LAT)
    ) u_acc_line (
        .clock (clock),
        .reset (reset),
        .d     (tag_q),
        .q     (acc_tag)
    );

    assign wr_d = {acc_tag.f.valid & acc_tag.f.last, acc_tag.out_addr};

    tag_delay_line #(
        .WIDTH (ADDR_W + 1),
        .DEPTH (MAC_LAT)
    ) u_wr_line (
        .clock (clock),
        .reset (reset),
        .d     (wr_d),
        .q     (wr_q)
    );

    assign acc_en    = acc_tag.f.valid;
    assign acc_clear = acc_tag.f.valid & acc_tag.f.first;
    assign out_we    = wr_q[ADDR_W];
    assign out_addr  = wr_q[ADDR_W-1:0];

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Scoreboard bench: a small layer (B) checked tap by tap against a
// loop-nest model, plus the default layer (A) for start/reset cases.
module tb_conv_addr_sequencer;

    localparam int BK = 2, BIN = 4, BINCH = 5, BOCH = 2, BLANES = 4;
    localparam int DL = 2, ML = 1;
    localparam int B_TAPS = BOCH * (BIN-BK+1) * (BIN-BK+1)
                          * ((BINCH+BLANES-1)/BLANES) * BK * BK;
    localparam int B_PIX  = BOCH * (BIN-BK+1) * (BIN-BK+1);

    typedef struct {
        int ifm;
        int wgt;
        int oad;
        bit first;
        bit last;
    } tap_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic a_reset, a_start, a_stall, a_busy, a_done, a_addr_valid;
    logic a_acc_clear, a_acc_en, a_out_we;
    logic [15:0] a_ifm, a_wgt, a_out_addr;
    logic b_reset, b_start, b_stall, b_busy, b_done, b_addr_valid;
    logic b_acc_clear, b_acc_en, b_out_we;
    logic [15:0] b_ifm, b_wgt, b_out_addr;

    conv_addr_sequencer u_a (
        .clock(clock), .reset(a_reset), .start(a_start), .stall(a_stall),
        .busy(a_busy), .done(a_done), .addr_valid(a_addr_valid),
        .ifm_addr(a_ifm), .weight_addr(a_wgt), .acc_clear(a_acc_clear),
        .acc_en(a_acc_en), .out_we(a_out_we), .out_addr(a_out_addr)
    );

    conv_addr_sequencer #(
        .K(BK), .IN_SIZE(BIN), .IN_CH(BINCH), .OUT_CH(BOCH),
        .LANES(BLANES), .ADDR_W(16), .DATA_LAT(DL), .MAC_LAT(ML)
    ) u_b (
        .clock(clock), .reset(b_reset), .start(b_start), .stall(b_stall),
        .busy(b_busy), .done(b_done), .addr_valid(b_addr_valid),
        .ifm_addr(b_ifm), .weight_addr(b_wgt), .acc_clear(b_acc_clear),
        .acc_en(b_acc_en), .out_we(b_out_we), .out_addr(b_out_addr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Reference: the layer as plain nested loops over the address formulas
    task automatic build_model(input int k, input int in_sz, input int in_ch,
                               input int out_ch, input int lanes,
                               input int max_n, output tap_t q[$]);
        int os, ng;
        tap_t t;
        os = in_sz - k + 1;
        ng = (in_ch + lanes - 1) / lanes;
        q = {};
        for (int m = 0; m < out_ch; m++)
            for (int r = 0; r < os; r++)
                for (int c = 0; c < os; c++)
                    for (int g = 0; g < ng; g++)
                        for (int i = 0; i < k; i++)
                            for (int j = 0; j < k; j++)
                                if (q.size() < max_n) begin
                                    t.ifm = g*in_sz*in_sz + (r+i)*in_sz + (c+j);
                                    t.wgt = m*ng*k*k + g*k*k + i*k + j;
                                    t.oad = m*os*os + r*os + c;
                                    t.first = (g == 0 && i == 0 && j == 0);
                                    t.last = (g == ng-1 && i == k-1 && j == k-1);
                                    q.push_back(t);
                                end
    endtask

    // ---------------- scoreboard monitor for instance B ----------------
    tap_t exp_q[$];
    int   acc_due[int];
    int   we_due[int];
    int   cyc = 0;
    int   done_due = -1;
    int   b_nvalid = 0;
    int   b_nwe = 0;
    int   cap_ifm = -1;
    int   cap_wgt = -1;
    tap_t mon_t;
    int   e_acc;
    bit   e_we;

    always @(negedge clock) begin
        if (!b_reset) begin
            cyc++;
            if (b_addr_valid) begin
                b_nvalid++;
                if (b_nvalid == 5) begin
                    cap_ifm = int'(b_ifm);
                    cap_wgt = int'(b_wgt);
                end
                if (exp_q.size() == 0) begin
                    check("extra_tap", 1, 0);
                end else begin
                    mon_t = exp_q.pop_front();
                    check("ifm_addr", b_ifm, mon_t.ifm);
                    check("weight_addr", b_wgt, mon_t.wgt);
                    acc_due[cyc+DL] = mon_t.first ? 3 : 2;
                    if (mon_t.last) we_due[cyc+DL+ML] = mon_t.oad;
                    if (exp_q.size() == 0) done_due = cyc + DL + ML + 1;
                end
            end
            e_acc = acc_due.exists(cyc) ? acc_due[cyc] : 0;
            if (e_acc != 0 || b_acc_en || b_acc_clear)
                check("acc_en_clear", {b_acc_en, b_acc_clear}, e_acc);
            e_we = we_due.exists(cyc);
            if (b_out_we) b_nwe++;
            if (e_we || b_out_we) begin
                check("out_we", b_out_we, e_we);
                if (e_we && b_out_we)
                    check("out_addr", b_out_addr, we_due[cyc]);
            end
            if (cyc == done_due || b_done)
                check("done_timing", b_done, cyc == done_due);
            if (acc_due.exists(cyc)) acc_due.delete(cyc);
            if (we_due.exists(cyc)) we_due.delete(cyc);
        end
    end

    // One layer on B; mode 0 = directed 3-cycle stall, else random
    task automatic run_b(input int mode);
        tap_t q[$];
        bit got_done;
        build_model(BK, BIN, BINCH, BOCH, BLANES, 1000000, q);
        @(negedge clock);
        b_nvalid = 0;
        b_nwe = 0;
        foreach (q[n]) exp_q.push_back(q[n]);
        b_start = 1'b1;
        @(negedge clock);
        b_start = 1'b0;
        got_done = 1'b0;
        for (int n = 0; n < 1500 && !got_done; n++) begin
            if (mode == 0) begin
                b_stall = (n >= 10 && n < 13);
            end else begin
                b_stall = ($urandom_range(0, 3) == 0);
                b_start = b_busy && ($urandom_range(0, 5) == 0);
            end
            @(negedge clock);
            if (b_done) got_done = 1'b1;
        end
        check("done_seen", got_done, 1);
        b_stall = 1'b0;
        b_start = 1'b1;
        @(negedge clock);
        b_start = 1'b0;
        repeat (3) @(negedge clock);
        check("idle_after_done", {b_busy, b_addr_valid}, 0);
        check("tap_count", b_nvalid, B_TAPS);
        check("we_count", b_nwe, B_PIX);
        check("queue_empty", exp_q.size(), 0);
        if (mode == 0) begin
            check("tap5_ifm", cap_ifm, 16);
            check("tap5_wgt", cap_wgt, 4);
        end
    endtask

    // Collect the first n issued taps on A, bounded by a cycle budget
    task automatic grab_a(input int n, output int ifm[$], output int wgt[$]);
        ifm = {};
        wgt = {};
        for (int k = 0; k < 60 && ifm.size() < n; k++) begin
            @(negedge clock);
            if (a_addr_valid) begin
                ifm.push_back(int'(a_ifm));
                wgt.push_back(int'(a_wgt));
            end
        end
        check("a_tap_collect", ifm.size(), n);
    endtask

    initial begin
        tap_t aq[$];
        int gi[$], gw[$];
        a_reset = 1'b1; b_reset = 1'b1;
        a_start = 1'b0; b_start = 1'b0;
        a_stall = 1'b0; b_stall = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_a", {a_busy, a_done, a_addr_valid, a_acc_clear, a_acc_en,
                          a_out_we, a_ifm, a_wgt, a_out_addr}, 0);
        check("reset_b", {b_busy, b_done, b_addr_valid, b_acc_clear, b_acc_en,
                          b_out_we, b_ifm, b_wgt, b_out_addr}, 0);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // default layer: first taps against model and known values
        build_model(5, 32, 1, 6, 4, 6, aq);
        @(negedge clock);
        a_start = 1'b1;
        @(negedge clock);
        a_start = 1'b0;
        check("a_busy", a_busy, 1);
        grab_a(6, gi, gw);
        for (int n = 0; n < 6 && n < gi.size(); n++) begin
            check("a_ifm_model", gi[n], aq[n].ifm);
            check("a_wgt_model", gw[n], aq[n].wgt);
        end
        if (gi.size() == 6) begin
            check("a_tap1", {gi[0], gw[0]}, {32'd0, 32'd0});
            check("a_tap2", {gi[1], gw[1]}, {32'd1, 32'd1});
            check("a_tap6", {gi[5], gw[5]}, {32'd32, 32'd5});
        end

        // asynchronous reset mid-RUN
        repeat (20) @(negedge clock);
        @(posedge clock);
        #2 a_reset = 1'b1;
        #1;
        check("a_async_reset", {a_busy, a_done, a_addr_valid, a_acc_clear,
                                a_acc_en, a_out_we, a_ifm, a_wgt, a_out_addr}, 0);
        @(negedge clock);
        a_reset = 1'b0;
        repeat (6) begin
            @(negedge clock);
            check("a_no_done", {a_done, a_busy, a_out_we}, 0);
        end
        a_start = 1'b1;
        @(negedge clock);
        a_start = 1'b0;
        grab_a(2, gi, gw);
        if (gi.size() == 2)
            check("a_replay", {gi[0], gw[0], gi[1], gw[1]},
                  {32'd0, 32'd0, 32'd1, 32'd1});
        a_reset = 1'b1;

        // small layer through the scoreboard
        run_b(0);
        run_b(1);
        run_b(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/conv_addr_sequencer.md
Name: conv_addr_sequencer

Overview:
- Self-sequencing address generator for the convolution datapath.
- Owns the full loop nest (m, r, c, g, i, j) with internal counters. Emits input-feature-map, weight and output-buffer addresses.
- Emits pipeline-aligned accumulator clear/enable and output write strobes, so the neuron/accumulator array needs no external loop indices.
- Start/done handshake toward the layer scheduler; stall input from memory arbitration.

Parameters:
K, 5, kernel side (stride 1, no padding)
IN_SIZE, 32, input feature map side
IN_CH, 1, input channel count
OUT_CH, 6, output channel count
LANES, 4, input channels processed in parallel; NG = ceil(IN_CH/LANES) channel groups
ADDR_W, 16, width of all address outputs
DATA_LAT, 2, cycles from address valid to operand data at accumulator
MAC_LAT, 1, cycles from last accumulate to result stable for output write
Derived: OUT_SIZE = IN_SIZE-K+1; TAPS = NG*K*K.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  one-cycle request to run a layer; sampled only in IDLE
stall  in  1  freeze loop counters this cycle (RUN only)
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse when the last output write has issued
addr_valid  out  1  ifm_addr/weight_addr valid this cycle
ifm_addr  out  ADDR_W  g*IN_SIZE^2 + (r+i)*IN_SIZE + (c+j)
weight_addr  out  ADDR_W  m*TAPS + g*K*K + i*K + j
acc_clear  out  1  first tap of an output pixel arrives at accumulator (load, not add)
acc_en  out  1  operand at accumulator is valid
out_we  out  1  write accumulated result
out_addr  out  ADDR_W  m*OUT_SIZE^2 + r*OUT_SIZE + c, qualified by out_we

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all counters 0; delay line flushed. Outputs busy, done, addr_valid, acc_clear, acc_en and out_we are 0. Addresses are 0.
- States: IDLE -> RUN on start; RUN -> DRAIN after last tap issued; DRAIN -> IDLE when delay line empty, with done=1 for that one cycle.
- RUN, stall=0: one tap per cycle. Addresses and addr_valid are registered, one cycle after counter state.
- Loop order, innermost first: j, i, g, c, r, m. Each counter wraps to 0 and carries to the next.
- RUN, stall=1: counters hold and addr_valid=0 next cycle. Addresses hold their last value.
- The delay line advances every cycle regardless of stall. Bubbles propagate as valid=0.
- Tag per issued tap: {valid, first (i=j=g=0), last (i=j=K-1, g=NG-1), out_addr}.
- acc_en and acc_clear equal tag valid and valid&first, delayed DATA_LAT cycles after addr_valid.
- out_we equals valid&last, delayed DATA_LAT+MAC_LAT cycles after addr_valid. out_addr is delivered in the same cycle.
- Partial last channel group (IN_CH not a multiple of LANES): the address is still issued. Lane masking belongs to the datapath.
- start while busy: ignored, no restart. start in the same cycle as done: ignored (IDLE is entered next cycle).
- stall in IDLE or DRAIN: ignored; drain always completes.
- Stall-free run: exactly OUT_CH*OUT_SIZE^2*TAPS addr_valid cycles and OUT_CH*OUT_SIZE^2 out_we cycles.
- done comes DATA_LAT+MAC_LAT+1 cycles after the last addr_valid, and in the cycle following the last out_we.
- Widths: counters use $clog2 of their range. Address arithmetic is unsigned, computed at 32 bits, truncated to ADDR_W.
- Elaboration error if any maximum address ≥ 2^ADDR_W, if K>IN_SIZE, or if LANES=0.
- Reset mid-RUN or mid-DRAIN: immediate return to IDLE. No done pulse; pending out_we are dropped.

Decomposition:
- conv_cfg_pkg holds: default layer constants (K, IN_SIZE, IN_CH, OUT_CH, LANES), the state enum (IDLE/RUN/DRAIN), the tag struct type, and the ceil-div/clog2 helper functions.
- One sub-module, tag_delay_line: parametrised WIDTH/DEPTH register chain with asynchronous reset to 0. It is instantiated twice, with depth DATA_LAT for accumulator tags and depth MAC_LAT for write tags.

Test Plan:
- Default params, start pulse, no stall: first addr_valid ifm=0, wgt=0; second ifm=1, wgt=1; sixth ifm=32, wgt=5. Exactly 4704*25 = 117600 valid cycles, 4704 out_we, final out_addr=4703, then one done.
- K=2, IN_SIZE=4, IN_CH=5, LANES=4, OUT_CH=2 (NG=2, TAPS=8): 144 valid cycles. Tap 5 has ifm_addr=16 and wgt_addr=4. 18 out_we at out_addr 0..17.
- Stall asserted 3 cycles mid-pixel: addr_valid drops for 3 cycles, address sequence resumes with no skipped or repeated tap, and acc_en shows a matching 3-cycle gap DATA_LAT later.
- acc_clear at pixel start, out_we timing: acc_clear high exactly DATA_LAT after tap 0 of each pixel. out_we exactly DATA_LAT+MAC_LAT after that pixel's last tap.
- start pulses during RUN and in the done cycle: no effect. A later start in IDLE begins again at address 0.
- Reset asserted mid-RUN: all outputs are 0 asynchronously, no done pulse, and a subsequent start replays from address 0.
